// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU/memory datapath and stalls on mem_ready.
// Optional build macro ILLEGAL_TRAP_EN traps unlisted opcodes into ERROR with a sticky flag.
module multicycle_ctrl #(
    parameter int unsigned TO_W        = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       Branch,
    output logic       bus_err,
    output logic       illegal_instr
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpNop    = 7'b0000000;

    // Last counter value that may still be waited on; one more idle cycle is a timeout.
    localparam logic [TO_W-1:0] CntLimit = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StExecU,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StLink,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              illegal_q, illegal_d;
    logic              waiting;

    logic              pc_update;
    logic              pc_write_raw;
    logic              ir_write_raw;
    logic              mem_write_raw;
    logic              reg_write_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    assign waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

    // Next state, wait counter and sticky flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;

        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (op)
                    OpLoad, OpStore:  state_d = StMemAdr;
                    OpRType:          state_d = StExecR;
                    OpIType:          state_d = StExecI;
                    OpLui, OpAuipc:   state_d = StExecU;
                    OpBranch:         state_d = StBranch;
                    OpJal:            state_d = StJal;
                    OpJalr:           state_d = StJalr;
                    OpNop:            state_d = StFetch;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = StError;
                        illegal_d = 1'b1;
`else
                        state_d   = StFetch;
`endif
                    end
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (mem_ready) state_d = StFetch;
            end
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StExecU:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StLink;
            StLink:     state_d = StAluWb;
            StError:    state_d = StError;
            default:    state_d = StError;
        endcase

        // A ready in the limit cycle still advances; only a missing ready times out.
        if (waiting && !mem_ready) begin
            if (cnt_q == CntLimit) begin
                state_d   = StError;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end
    end

    // Moore outputs per state; FETCH enables follow mem_ready.
    always_comb begin
        pc_update     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        Branch        = 1'b0;

        case (state_q)
            StFetch: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            StMemWrite: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            StExecU: begin
                ALUSrcA = (op == OpAuipc) ? 2'b01 : 2'b11;
                ALUSrcB = 2'b01;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            StJal: begin
                pc_update = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
            end
            StJalr: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            StLink: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OpStore:        ImmSrc = 3'b001;
            OpBranch:       ImmSrc = 3'b010;
            OpJal:          ImmSrc = 3'b011;
            OpLui, OpAuipc: ImmSrc = 3'b100;
            default:        ImmSrc = 3'b000;
        endcase
    end

    assign pc_write_raw = pc_update | (Branch & branch_taken);

    // Enables are killed combinationally so an asynchronous reset stops strobes at once.
    assign PCWrite  = pc_write_raw & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign bus_err  = bus_err_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction-level model expands each opcode into its phase
// list, and every cycle the DUT outputs are compared against the phase table.
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 5;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] NOP   = 7'b0000000;
    localparam logic [6:0] BAD   = 7'b1111111;

    typedef enum int {PF, PD, PMA, PMR, PMWB, PMW, PER, PEI, PEU, PAWB, PBR, PJAL, PJALR,
                      PLINK, PERR} ph_t;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aluop;
        logic [2:0] imm;
        logic       br;
        logic       berr;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       taken;
        logic       rdy;
        logic       rst;
        ph_t        ph;
        logic       berr;
        logic       ill;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, bus_err, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    multicycle_ctrl #(
        .TO_W        (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .MemWrite      (MemWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .ImmSrc        (ImmSrc),
        .Branch        (Branch),
        .bus_err       (bus_err),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    bit   m_bus = 1'b0;
    bit   m_ill = 1'b0;
    cyc_t q[$];

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            SW:         return 3'b001;
            BEQ:        return 3'b010;
            JAL:        return 3'b011;
            LUI, AUIPC: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic outs_t expect_out(input cyc_t c);
        outs_t o;
        o      = '0;
        o.imm  = imm_of(c.op);
        o.berr = c.berr;
        o.ill  = c.ill;
        case (c.ph)
            PF:    begin o.b = 2'b10; o.res = 2'b10; o.irw = c.rdy; o.pcw = c.rdy; end
            PD:    begin o.a = 2'b01; o.b = 2'b01; end
            PMA:   begin o.a = 2'b10; o.b = 2'b01; end
            PMR:   begin o.adr = 1'b1; end
            PMWB:  begin o.res = 2'b01; o.regw = 1'b1; end
            PMW:   begin o.adr = 1'b1; o.memw = 1'b1; end
            PER:   begin o.a = 2'b10; o.aluop = 2'b10; end
            PEI:   begin o.a = 2'b10; o.b = 2'b01; o.aluop = 2'b10; end
            PEU:   begin o.a = (c.op == AUIPC) ? 2'b01 : 2'b11; o.b = 2'b01; end
            PAWB:  begin o.regw = 1'b1; end
            PBR:   begin o.a = 2'b10; o.aluop = 2'b01; o.br = 1'b1; o.pcw = c.taken; end
            PJAL:  begin o.pcw = 1'b1; o.a = 2'b01; o.b = 2'b10; end
            PJALR: begin o.a = 2'b10; o.b = 2'b01; o.res = 2'b10; o.pcw = 1'b1; end
            PLINK: begin o.a = 2'b01; o.b = 2'b10; end
            default: ;
        endcase
        if (c.rst) begin
            o.pcw  = 1'b0;
            o.irw  = 1'b0;
            o.memw = 1'b0;
            o.regw = 1'b0;
        end
        return o;
    endfunction

    task automatic push(input logic [6:0] o, input ph_t ph, input logic rdy, input logic tk);
        cyc_t c;
        c.op    = o;
        c.ph    = ph;
        c.rdy   = rdy;
        c.taken = tk;
        c.rst   = 1'b0;
        c.berr  = m_bus;
        c.ill   = m_ill;
        q.push_back(c);
    endtask

    // Non-waiting phases ignore mem_ready, so drive it randomly there.
    task automatic push_any(input logic [6:0] o, input ph_t ph, input logic tk);
        push(o, ph, 1'($urandom_range(0, 1)), tk);
    endtask

    task automatic wait_phase(input logic [6:0] o, input ph_t ph, input int nwait, input logic tk,
                              output bit to);
        to = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            push(o, ph, 1'b0, tk);
            if (i == int'(TMO) - 1) begin
                to = 1'b1;
                break;
            end
        end
        if (to) begin
            m_bus = 1'b1;
            push_any(o, PERR, tk);
        end else begin
            push(o, ph, 1'b1, tk);
        end
    endtask

    task automatic instr(input logic [6:0] o, input logic tk, input int fw, input int mw);
        bit to;
        wait_phase(o, PF, fw, tk, to);
        if (to) return;
        push_any(o, PD, tk);
        case (o)
            LW: begin
                push_any(o, PMA, tk);
                wait_phase(o, PMR, mw, tk, to);
                if (!to) push_any(o, PMWB, tk);
            end
            SW: begin
                push_any(o, PMA, tk);
                wait_phase(o, PMW, mw, tk, to);
            end
            ADD:        begin push_any(o, PER, tk); push_any(o, PAWB, tk); end
            ADDI:       begin push_any(o, PEI, tk); push_any(o, PAWB, tk); end
            LUI, AUIPC: begin push_any(o, PEU, tk); push_any(o, PAWB, tk); end
            BEQ:        push_any(o, PBR, tk);
            JAL:        begin push_any(o, PJAL, tk); push_any(o, PAWB, tk); end
            JALR: begin
                push_any(o, PJALR, tk);
                push_any(o, PLINK, tk);
                push_any(o, PAWB, tk);
            end
            NOP: ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
                m_ill = 1'b1;
                push_any(o, PERR, tk);
`endif
            end
        endcase
    endtask

    task automatic do_reset(input int n);
        cyc_t c;
        m_bus = 1'b0;
        m_ill = 1'b0;
        for (int i = 0; i < n; i++) begin
            c.op    = ADD;
            c.ph    = PF;
            c.rdy   = 1'b1;
            c.taken = 1'b1;
            c.rst   = 1'b1;
            c.berr  = 1'b0;
            c.ill   = 1'b0;
            q.push_back(c);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic instr_len(input string name, input logic [6:0] o, input logic tk, input int len);
        int n0;
        n0 = q.size();
        instr(o, tk, 0, 0);
        check(name, q.size() - n0, len);
    endtask

    initial begin
        outs_t exp_o;
        outs_t got_o;

        do_reset(2);
        instr_len("len_add", ADD, 1'b1, 4);
        instr_len("len_lw", LW, 1'b0, 5);
        instr_len("len_sw", SW, 1'b1, 4);
        instr_len("len_beq_t", BEQ, 1'b1, 3);
        instr_len("len_beq_nt", BEQ, 1'b0, 3);
        instr_len("len_jal", JAL, 1'b1, 4);
        instr_len("len_jalr", JALR, 1'b0, 5);
        instr_len("len_addi", ADDI, 1'b0, 4);
        instr_len("len_lui", LUI, 1'b0, 4);
        instr_len("len_auipc", AUIPC, 1'b1, 4);
        instr(LW, 1'b0, 0, 3);
        instr(ADD, 1'b0, 2, 0);
        instr(LW, 1'b1, 0, int'(TMO) - 1);
        instr(SW, 1'b0, int'(TMO) - 1, int'(TMO) - 1);
        instr(NOP, 1'b1, 0, 0);
        instr(BAD, 1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        push_any(BAD, PERR, 1'b0);
        push_any(BAD, PERR, 1'b1);
        do_reset(1);
`endif
        instr(SW, 1'b0, 0, int'(TMO));
        push_any(SW, PERR, 1'b0);
        push_any(SW, PERR, 1'b1);
        push(SW, PERR, 1'b1, 1'b0);
        do_reset(2);
        instr(ADDI, 1'b1, 0, 0);
        push(SW, PF, 1'b1, 1'b0);
        push_any(SW, PD, 1'b0);
        push_any(SW, PMA, 1'b0);
        push(SW, PMW, 1'b0, 1'b0);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            reset        = q[i].rst;
            op           = q[i].op;
            branch_taken = q[i].taken;
            mem_ready    = q[i].rdy;
            @(negedge clk);
            exp_o = expect_out(q[i]);
            got_o = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ALUOp, ImmSrc, Branch, bus_err, illegal_instr};
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL cycle %0d phase %s op=%b: outputs got %h, expected %h",
                         i, q[i].ph.name(), q[i].op, got_o, exp_o);
            end
        end

        // Asynchronous reset while the store strobe is active.
        check("memw_before_rst", int'(MemWrite), 1);
        #2;
        reset = 1'b1;
        #1;
        check("memw_async_rst", int'(MemWrite), 0);
        check("regw_async_rst", int'(RegWrite), 0);
        check("adrsrc_async_rst", int'(AdrSrc), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("fetch_res_after_rst", int'(ResultSrc), 2);
        check("fetch_srcb_after_rst", int'(ALUSrcB), 2);
        check("fetch_irw_no_ready", int'(IRWrite), 0);
        mem_ready = 1'b1;
        #1;
        check("fetch_irw_ready", int'(IRWrite), 1);
        check("fetch_pcw_ready", int'(PCWrite), 1);
        check("bus_err_after_rst", int'(bus_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
